mac_tx_framer: RTL

//  Tx framing stage directly downstream of mac_subset: consumes its byte stream (mac_data/strobe_s)

---
 rtl/mac_tx_framer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mac_tx_framer.sv
// mac_tx_framer: Ethernet Tx framing stage.
// Takes a body byte stream (destination MAC onward) and emits preamble+SFD,
// the body, optional zero padding, CRC-32 FCS, then an enforced idle gap.
// Build option: define MAC_TX_FRAMER_PAD_EN to zero-pad short bodies to
// MIN_BODY bytes before the FCS. Without it, the FCS follows the last body byte.
module mac_tx_framer #(
  parameter int IFG_LEN  = 12
`ifdef MAC_TX_FRAMER_PAD_EN
  , parameter int MIN_BODY = 60
`endif
) (
  input  logic        tx_clk,
  input  logic        tx_rst,
  input  logic        ce,
  input  logic [7:0]  in_data,
  input  logic        in_strobe,
  output logic [7:0]  out_data,
  output logic        out_strobe,
  output logic        overrun_err,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_BODY = 3'd2,
`ifdef MAC_TX_FRAMER_PAD_EN
    S_PAD  = 3'd3,
`endif
    S_FCS  = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        pre_cnt_q, pre_cnt_d;
  logic [10:0]       cnt_q, cnt_d;
  logic [1:0]        fcs_cnt_q, fcs_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [31:0]       crc_q, crc_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              in_prev_q, in_active_q, in_active_d;
  logic [7:0][7:0]   dl_data_q;
  logic [7:0]        dl_vld_q;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_strobe_q, out_strobe_d;
  logic              overrun_q, overrun_d;

  logic              rise, start, take, need_pad;
  logic [7:0]        dl_out;
  logic              dl_out_vld;
  logic [31:0]       fcs;

  // Reflected CRC-32 (poly 04C11DB7), one byte per call, LSB first
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // in_prev_q resets high so a strobe already high at reset release is not a rise
  assign rise       = in_strobe & ~in_prev_q;
  assign start      = rise & (state_q == S_IDLE);
  // Only bytes of an accepted frame enter the delay line as valid
  assign take       = in_strobe & (in_active_q | start);
  assign in_active_d = start | (in_active_q & in_strobe);
  assign overrun_d  = rise & (state_q != S_IDLE);
  assign dl_out     = dl_data_q[7];
  assign dl_out_vld = dl_vld_q[7];
  assign fcs        = ~crc_q;

`ifdef MAC_TX_FRAMER_PAD_EN
  assign need_pad = (cnt_q < 11'(MIN_BODY));
`else
  assign need_pad = 1'b0;
`endif

  // State register plus all ce-qualified datapath state
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_q       <= S_IDLE;
      pre_cnt_q     <= '0;
      cnt_q         <= '0;
      fcs_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      crc_q         <= 32'hFFFF_FFFF;
      frame_count_q <= '0;
      in_prev_q     <= 1'b1;
      in_active_q   <= 1'b0;
      dl_data_q     <= '0;
      dl_vld_q      <= '0;
      out_data_q    <= '0;
      out_strobe_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else if (ce) begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      cnt_q         <= cnt_d;
      fcs_cnt_q     <= fcs_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      crc_q         <= crc_d;
      frame_count_q <= frame_count_d;
      in_prev_q     <= in_strobe;
      in_active_q   <= in_active_d;
      dl_data_q     <= {dl_data_q[6:0], in_data};
      dl_vld_q      <= {dl_vld_q[6:0], take};
      out_data_q    <= out_data_d;
      out_strobe_q  <= out_strobe_d;
      overrun_q     <= overrun_d;
    end
  end

  // Next-state and counter/CRC updates
  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    cnt_d         = cnt_q;
    fcs_cnt_d     = fcs_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    crc_d         = crc_q;
    frame_count_d = frame_count_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_PRE;
        pre_cnt_d = 3'd1;
        cnt_d     = '0;
        crc_d     = 32'hFFFF_FFFF;
      end
      S_PRE: begin
        pre_cnt_d = pre_cnt_q + 3'd1;
        if (pre_cnt_q == 3'd7) state_d = S_BODY;
      end
      S_BODY: begin
        if (dl_out_vld) begin
          crc_d = crc_upd(crc_q, dl_out);
          cnt_d = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
`ifdef MAC_TX_FRAMER_PAD_EN
        end else if (need_pad) begin
          state_d = S_PAD;
          crc_d   = crc_upd(crc_q, 8'h00);
          cnt_d   = cnt_q + 11'd1;
`endif
        end else begin
          state_d   = S_FCS;
          fcs_cnt_d = 2'd1;
        end
      end
`ifdef MAC_TX_FRAMER_PAD_EN
      S_PAD: begin
        if (need_pad) begin
          crc_d = crc_upd(crc_q, 8'h00);
          cnt_d = cnt_q + 11'd1;
        end else begin
          state_d   = S_FCS;
          fcs_cnt_d = 2'd1;
        end
      end
`endif
      S_FCS: begin
        fcs_cnt_d = fcs_cnt_q + 2'd1;
        if (fcs_cnt_q == 2'd3) begin
          state_d       = S_GAP;
          gap_cnt_d     = '0;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 8'd1;
        if (gap_cnt_q == 8'(IFG_LEN - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte driven on this edge; the first pad/FCS byte goes out on the edge the body ends
  always_comb begin
    out_data_d   = 8'h00;
    out_strobe_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        out_data_d   = 8'h55;
        out_strobe_d = 1'b1;
      end
      S_PRE: begin
        out_data_d   = (pre_cnt_q == 3'd7) ? 8'hD5 : 8'h55;
        out_strobe_d = 1'b1;
      end
      S_BODY: begin
        out_strobe_d = 1'b1;
        if (dl_out_vld)    out_data_d = dl_out;
        else if (need_pad) out_data_d = 8'h00;
        else               out_data_d = fcs[7:0];
      end
`ifdef MAC_TX_FRAMER_PAD_EN
      S_PAD: begin
        out_strobe_d = 1'b1;
        out_data_d   = need_pad ? 8'h00 : fcs[7:0];
      end
`endif
      S_FCS: begin
        out_strobe_d = 1'b1;
        out_data_d   = fcs[8*fcs_cnt_q +: 8];
      end
      default: ;
    endcase
  end

  assign out_data    = out_data_q;
  assign out_strobe  = out_strobe_q;
  assign overrun_err = overrun_q;
  assign frame_count = frame_count_q;

endmodule
